// File: rtl/ppu_timing_pkg.sv
// Timing constants and shared position type for the PPU dot/scanline counter.
// NTSC values are the defaults; PAL alternates are provided for alternate builds.
package ppu_timing_pkg;

  localparam int CNT_W = 9;

  localparam int H_TOTAL  = 341;
  localparam int V_TOTAL  = 262;
  localparam int VBL_LINE = 241;
  localparam int PRE_LINE = 261;
  localparam int EVT_DOT  = 1;

  localparam int PAL_V_TOTAL  = 312;
  localparam int PAL_VBL_LINE = 241;
  localparam int PAL_PRE_LINE = 311;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
  } hv_pos_t;

  function automatic logic at_pos(hv_pos_t p, int h, int v);
    return (p.h == cnt_t'(h)) && (p.v == cnt_t'(v));
  endfunction

endpackage

// File: rtl/ppu_hv_counter.sv
// Dot/scanline wrap counters with frame parity; exposes the next position for event decode.
// Define PPU_ODD_SKIP_EN to drop the last pre-render dot on odd frames while rendering.
module ppu_hv_counter #(
  parameter int H_TOTAL = ppu_timing_pkg::H_TOTAL,
  parameter int V_TOTAL = ppu_timing_pkg::V_TOTAL
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            rendering_en,
  output logic [ppu_timing_pkg::CNT_W-1:0] h_cnt,
  output logic [ppu_timing_pkg::CNT_W-1:0] v_cnt,
  output logic                            odd_frame,
  output ppu_timing_pkg::hv_pos_t         pos_nxt
);
  import ppu_timing_pkg::*;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic odd_q, odd_d;
  logic skip;

`ifdef PPU_ODD_SKIP_EN
  // The pre-render line is always the last line of the frame.
  localparam cnt_t H_SKIP = cnt_t'(H_TOTAL - 2);
  assign skip = (v_q == V_LAST) && (h_q == H_SKIP) && odd_q && rendering_en;
`else
  logic unused_rendering_en;
  assign unused_rendering_en = rendering_en;
  assign skip = 1'b0;
`endif

  always_comb begin
    h_d   = h_q + cnt_t'(1);
    v_d   = v_q;
    odd_d = odd_q;
    if (skip || (h_q == H_LAST)) begin
      h_d = '0;
      if (skip || (v_q == V_LAST)) begin
        v_d   = '0;
        odd_d = ~odd_q;
      end else begin
        v_d = v_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      h_q   <= '0;
      v_q   <= '0;
      odd_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      odd_q <= odd_d;
    end
  end

  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign odd_frame = odd_q;
  assign pos_nxt   = {h_d, v_d};

endmodule

// File: rtl/ppu_vbl_event_gen.sv
// VBlank set/reset strobe generator: decodes events from the next counter position so the
// registered strobes line up with the displayed coordinate. Optional macro: PPU_ODD_SKIP_EN.
module ppu_vbl_event_gen #(
  parameter int H_TOTAL  = ppu_timing_pkg::H_TOTAL,
  parameter int V_TOTAL  = ppu_timing_pkg::V_TOTAL,
  parameter int VBL_LINE = ppu_timing_pkg::VBL_LINE,
  parameter int PRE_LINE = ppu_timing_pkg::PRE_LINE,
  parameter int EVT_DOT  = ppu_timing_pkg::EVT_DOT
) (
  input  logic                             CLK,
  input  logic                             RES,
  input  logic                             rd_status,
  input  logic                             rendering_en,
  output logic [ppu_timing_pkg::CNT_W-1:0] h_cnt,
  output logic [ppu_timing_pkg::CNT_W-1:0] v_cnt,
  output logic                             odd_frame,
  output logic                             vbl_set,
  output logic                             vbl_rst,
  output logic                             vbl_flag
);
  import ppu_timing_pkg::*;

  hv_pos_t pos_nxt;
  logic    set_evt, pre_evt;
  logic    vbl_set_d, vbl_set_q;
  logic    vbl_rst_d, vbl_rst_q;
  logic    vbl_flag_d, vbl_flag_q;

  ppu_hv_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_hv (
    .clk         (CLK),
    .res         (RES),
    .rendering_en(rendering_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .odd_frame   (odd_frame),
    .pos_nxt     (pos_nxt)
  );

  // A status read landing on the set dot wins, so the latch never sees set and reset together.
  always_comb begin
    set_evt    = at_pos(pos_nxt, EVT_DOT, VBL_LINE);
    pre_evt    = at_pos(pos_nxt, EVT_DOT, PRE_LINE);
    vbl_set_d  = set_evt && !rd_status;
    vbl_rst_d  = pre_evt || rd_status;
    vbl_flag_d = vbl_flag_q;
    if (vbl_set_q) begin
      vbl_flag_d = 1'b1;
    end else if (vbl_rst_q) begin
      vbl_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      vbl_set_q  <= 1'b0;
      vbl_rst_q  <= 1'b0;
      vbl_flag_q <= 1'b0;
    end else begin
      vbl_set_q  <= vbl_set_d;
      vbl_rst_q  <= vbl_rst_d;
      vbl_flag_q <= vbl_flag_d;
    end
  end

  assign vbl_set  = vbl_set_q;
  assign vbl_rst  = vbl_rst_q;
  assign vbl_flag = vbl_flag_q;

endmodule

// File: tb/tb_ppu_vbl_event_gen.sv
// Bench for ppu_vbl_event_gen: a full NTSC frame on a default instance, plus scenario and
// randomized checks on a reduced-timing instance against a dot-index reference model.
module tb_ppu_vbl_event_gen;

  localparam int TH     = 20;
  localparam int TV     = 12;
  localparam int TVBL   = 7;
  localparam int TPRE   = 11;
  localparam int TEVT   = 1;
  localparam int TFRAME = TH * TV;

`ifdef PPU_ODD_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1;
  logic       rd_status = 1'b0;
  logic       rendering_en = 1'b0;
  logic [8:0] h_cnt, v_cnt;
  logic       odd_frame, vbl_set, vbl_rst, vbl_flag;

  ppu_vbl_event_gen #(
    .H_TOTAL(TH), .V_TOTAL(TV), .VBL_LINE(TVBL), .PRE_LINE(TPRE), .EVT_DOT(TEVT)
  ) dut (
    .CLK(clk), .RES(res), .rd_status(rd_status), .rendering_en(rendering_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .odd_frame(odd_frame),
    .vbl_set(vbl_set), .vbl_rst(vbl_rst), .vbl_flag(vbl_flag)
  );

  logic       n_res = 1'b1;
  logic [8:0] n_h, n_v;
  logic       n_odd, n_set, n_rst, n_flag;

  ppu_vbl_event_gen dut_ntsc (
    .CLK(clk), .RES(n_res), .rd_status(1'b0), .rendering_en(1'b0),
    .h_cnt(n_h), .v_cnt(n_v), .odd_frame(n_odd),
    .vbl_set(n_set), .vbl_rst(n_rst), .vbl_flag(n_flag)
  );

  // Reference model: position is a dot index within the frame; the flag is 1 when the most
  // recent set strobe is newer than the most recent reset strobe.
  int   m_idx = 0;
  logic m_odd = 1'b0;
  int   cyc = 0;
  int   last_set = -1;
  int   last_rst = -1;
  logic m_set = 1'b0, m_rst = 1'b0, m_flag = 1'b0;

  function automatic int m_h();
    return m_idx % TH;
  endfunction

  function automatic int m_v();
    return m_idx / TH;
  endfunction

  function automatic int dh();
    return int'(h_cnt);
  endfunction

  function automatic int dv();
    return int'(v_cnt);
  endfunction

  task automatic tick();
    logic rd_now, ren_now, res_now;
    rd_now  = rd_status;
    ren_now = rendering_en;
    res_now = res;
    @(posedge clk);
    #1;
    cyc++;
    if (res_now) begin
      m_idx = 0; m_odd = 1'b0; m_set = 1'b0; m_rst = 1'b0; m_flag = 1'b0;
      last_set = -1; last_rst = -1;
    end else begin
      if (SKIP && m_idx == TFRAME - 2 && m_odd && ren_now) begin
        m_idx = 0; m_odd = !m_odd;
      end else if (m_idx == TFRAME - 1) begin
        m_idx = 0; m_odd = !m_odd;
      end else begin
        m_idx++;
      end
      m_set  = (m_h() == TEVT && m_v() == TVBL) && !rd_now;
      m_rst  = (m_h() == TEVT && m_v() == TPRE) || rd_now;
      m_flag = last_set > last_rst;
      if (m_set) last_set = cyc;
      if (m_rst) last_rst = cyc;
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * TFRAME && !(m_h() == h && m_v() == v); i++) tick();
  endtask

  task automatic do_reset();
    res = 1'b1; tick(); res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; rd_status = 1'b1; rendering_en = 1'b1;
    tick(); tick();
    checks++; if (h_cnt !== 9'd0) begin failures++; $display("[TB] FAIL reset_h got %0d want 0", h_cnt); end
    checks++; if (v_cnt !== 9'd0) begin failures++; $display("[TB] FAIL reset_v got %0d want 0", v_cnt); end
    checks++; if (odd_frame !== 1'b0) begin failures++; $display("[TB] FAIL reset_odd got %b want 0", odd_frame); end
    checks++; if (vbl_set !== 1'b0) begin failures++; $display("[TB] FAIL reset_set got %b want 0", vbl_set); end
    checks++; if (vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL reset_rst got %b want 0", vbl_rst); end
    checks++; if (vbl_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag got %b want 0", vbl_flag); end
    res = 1'b0; rd_status = 1'b0; rendering_en = 1'b0;
    tick();
    checks++; if (dh() != 1 || dv() != 0) begin failures++; $display("[TB] FAIL reset_release got (%0d,%0d) want (1,0)", h_cnt, v_cnt); end
  endtask

  task automatic test_ntsc_frame();
    int ns, nr, nboth, nflag, sh, sv, rh, rv;
    ns = 0; nr = 0; nboth = 0; nflag = 0; sh = -1; sv = -1; rh = -1; rv = -1;
    n_res = 1'b1; @(posedge clk); #1; n_res = 1'b0;
    for (int i = 0; i < ppu_timing_pkg::H_TOTAL * ppu_timing_pkg::V_TOTAL; i++) begin
      @(posedge clk); #1;
      if (n_set) begin ns++; sh = int'(n_h); sv = int'(n_v); end
      if (n_rst) begin nr++; rh = int'(n_h); rv = int'(n_v); end
      if (n_set && n_rst) nboth++;
      if (n_flag) nflag++;
    end
    checks++; if (ns != 1) begin failures++; $display("[TB] FAIL ntsc_set_count got %0d want 1", ns); end
    checks++; if (sh != 1 || sv != 241) begin failures++; $display("[TB] FAIL ntsc_set_pos got (%0d,%0d) want (1,241)", sh, sv); end
    checks++; if (nr != 1) begin failures++; $display("[TB] FAIL ntsc_rst_count got %0d want 1", nr); end
    checks++; if (rh != 1 || rv != 261) begin failures++; $display("[TB] FAIL ntsc_rst_pos got (%0d,%0d) want (1,261)", rh, rv); end
    checks++; if (nboth != 0) begin failures++; $display("[TB] FAIL ntsc_overlap got %0d want 0", nboth); end
    checks++; if (nflag != 20 * 341) begin failures++; $display("[TB] FAIL ntsc_flag_cycles got %0d want %0d", nflag, 20 * 341); end
    checks++; if (n_h !== 9'd0 || n_v !== 9'd0) begin failures++; $display("[TB] FAIL ntsc_wrap got (%0d,%0d) want (0,0)", n_h, n_v); end
    checks++; if (n_odd !== 1'b1) begin failures++; $display("[TB] FAIL ntsc_odd got %b want 1", n_odd); end
  endtask

  task automatic test_race();
    int nset, nflag;
    nset = 0; nflag = 0;
    do_reset();
    run_to(0, TVBL);
    rd_status = 1'b1; tick(); rd_status = 1'b0;
    checks++; if (vbl_set !== 1'b0) begin failures++; $display("[TB] FAIL race_set got %b want 0", vbl_set); end
    checks++; if (vbl_rst !== 1'b1) begin failures++; $display("[TB] FAIL race_rst got %b want 1", vbl_rst); end
    checks++; if (dh() != 1 || dv() != TVBL) begin failures++; $display("[TB] FAIL race_pos got (%0d,%0d) want (1,%0d)", h_cnt, v_cnt, TVBL); end
    for (int i = 0; i < 2 * TFRAME && !(m_h() == 0 && m_v() == 0); i++) begin
      tick();
      if (vbl_set) nset++;
      if (vbl_flag) nflag++;
    end
    checks++; if (nset != 0) begin failures++; $display("[TB] FAIL race_frame_set got %0d want 0", nset); end
    checks++; if (nflag != 0) begin failures++; $display("[TB] FAIL race_frame_flag got %0d want 0", nflag); end
    run_to(1, TVBL);
    checks++; if (vbl_set !== 1'b1) begin failures++; $display("[TB] FAIL race_next_set got %b want 1", vbl_set); end
    tick();
    checks++; if (vbl_flag !== 1'b1) begin failures++; $display("[TB] FAIL race_next_flag got %b want 1", vbl_flag); end
  endtask

  task automatic test_read_clear();
    int nset;
    nset = 0;
    run_to(10, TVBL + 2);
    checks++; if (vbl_flag !== 1'b1) begin failures++; $display("[TB] FAIL rd_pre_flag got %b want 1", vbl_flag); end
    rd_status = 1'b1; tick(); rd_status = 1'b0;
    checks++; if (vbl_rst !== 1'b1) begin failures++; $display("[TB] FAIL rd_rst got %b want 1", vbl_rst); end
    checks++; if (dh() != 11 || dv() != TVBL + 2) begin failures++; $display("[TB] FAIL rd_pos got (%0d,%0d) want (11,%0d)", h_cnt, v_cnt, TVBL + 2); end
    checks++; if (vbl_flag !== 1'b1) begin failures++; $display("[TB] FAIL rd_flag_hold got %b want 1", vbl_flag); end
    tick();
    checks++; if (vbl_flag !== 1'b0) begin failures++; $display("[TB] FAIL rd_flag_clear got %b want 0", vbl_flag); end
    checks++; if (vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL rd_rst_single got %b want 0", vbl_rst); end
    for (int i = 0; i < 2 * TFRAME && !(m_h() == 0 && m_v() == 0); i++) begin
      tick();
      if (vbl_set) nset++;
    end
    checks++; if (nset != 0) begin failures++; $display("[TB] FAIL rd_no_set got %0d want 0", nset); end
  endtask

  task automatic test_back_to_back();
    run_to(5, 2);
    rd_status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vbl_rst !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rst_%0d got %b want 1", i, vbl_rst); end
    end
    rd_status = 1'b0;
    tick();
    checks++; if (vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stop got %b want 0", vbl_rst); end
    tick();
    checks++; if (vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_accum got %b want 0", vbl_rst); end
  endtask

  task automatic test_reset_mid();
    run_to(12, 4);
    res = 1'b1; rd_status = 1'b1; tick(); res = 1'b0; rd_status = 1'b0;
    checks++; if (h_cnt !== 9'd0 || v_cnt !== 9'd0) begin failures++; $display("[TB] FAIL mid_reset_pos got (%0d,%0d) want (0,0)", h_cnt, v_cnt); end
    checks++; if (odd_frame !== 1'b0 || vbl_flag !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_odd_flag got %b%b want 00", odd_frame, vbl_flag); end
    checks++; if (vbl_set !== 1'b0 || vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_strobe got %b%b want 00", vbl_set, vbl_rst); end
    tick();
    checks++; if (dh() != 1 || dv() != 0) begin failures++; $display("[TB] FAIL mid_resume got (%0d,%0d) want (1,0)", h_cnt, v_cnt); end
    checks++; if (vbl_set !== 1'b0 || vbl_rst !== 1'b0) begin failures++; $display("[TB] FAIL mid_spurious got %b%b want 00", vbl_set, vbl_rst); end
  endtask

  task automatic measure_frame(output int len, output int ah, output int av);
    int ph, pv;
    len = 0; ah = -1; av = -1;
    do begin
      ph = dh(); pv = dv();
      tick();
      len++;
      if (ph == TH - 2 && pv == TPRE) begin ah = dh(); av = dv(); end
    end while (!(h_cnt == 9'd0 && v_cnt == 9'd0) && len < 2 * TFRAME);
  endtask

  task automatic test_skip(input logic ren);
    int len, ah, av, want_len, want_h, want_v;
    do_reset();
    rendering_en = ren;
    measure_frame(len, ah, av);
    checks++; if (len != TFRAME) begin failures++; $display("[TB] FAIL skip%0d_even_len got %0d want %0d", ren, len, TFRAME); end
    checks++; if (odd_frame !== 1'b1) begin failures++; $display("[TB] FAIL skip%0d_parity got %b want 1", ren, odd_frame); end
    want_len = (SKIP && ren) ? TFRAME - 1 : TFRAME;
    want_h   = (SKIP && ren) ? 0 : TH - 1;
    want_v   = (SKIP && ren) ? 0 : TPRE;
    measure_frame(len, ah, av);
    checks++; if (len != want_len) begin failures++; $display("[TB] FAIL skip%0d_odd_len got %0d want %0d", ren, len, want_len); end
    checks++; if (ah != want_h || av != want_v) begin failures++; $display("[TB] FAIL skip%0d_succ got (%0d,%0d) want (%0d,%0d)", ren, ah, av, want_h, want_v); end
    checks++; if (odd_frame !== 1'b0) begin failures++; $display("[TB] FAIL skip%0d_parity2 got %b want 0", ren, odd_frame); end
    rendering_en = 1'b0;
  endtask

  task automatic test_random();
    int n_both, n_set, n_rst, n_flag, n_pos;
    n_both = 0; n_set = 0; n_rst = 0; n_flag = 0; n_pos = 0;
    do_reset();
    for (int i = 0; i < 10 * TFRAME; i++) begin
      rd_status    = ($urandom_range(15, 0) == 0);
      rendering_en = 1'($urandom_range(1, 0));
      if (m_h() == 0 && m_v() == TVBL && ((i / TFRAME) % 2) == 1) rd_status = 1'b1;
      tick();
      if (vbl_set && vbl_rst) n_both++;
      if (vbl_set !== m_set) n_set++;
      if (vbl_rst !== m_rst) n_rst++;
      if (vbl_flag !== m_flag) n_flag++;
      if (dh() != m_h() || dv() != m_v() || odd_frame !== m_odd) n_pos++;
    end
    rd_status = 1'b0; rendering_en = 1'b0;
    checks++; if (n_both != 0) begin failures++; $display("[TB] FAIL rand_overlap got %0d want 0", n_both); end
    checks++; if (n_set != 0) begin failures++; $display("[TB] FAIL rand_set got %0d bad cycles want 0", n_set); end
    checks++; if (n_rst != 0) begin failures++; $display("[TB] FAIL rand_rst got %0d bad cycles want 0", n_rst); end
    checks++; if (n_flag != 0) begin failures++; $display("[TB] FAIL rand_flag got %0d bad cycles want 0", n_flag); end
    checks++; if (n_pos != 0) begin failures++; $display("[TB] FAIL rand_pos got %0d bad cycles want 0", n_pos); end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    fork
      test_ntsc_frame();
      begin
        test_reset();
        test_race();
        test_read_clear();
        test_back_to_back();
        test_reset_mid();
        test_skip(1'b1);
        test_skip(1'b0);
        test_random();
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
